// File: rtl/control_unit_pkg.sv
// control_unit_pkg: bit offsets of the instruction fields the front end decodes.
// No ports.
package control_unit_pkg;

    localparam int RS_LSB = 21;
    localparam int RT_LSB = 16;
    localparam int OP_LSB = 26;

endpackage

// File: rtl/cpu_types_pkg.sv
// cpu_types_pkg: machine-wide word, register-index and opcode types.
// No ports; imported by the decode/issue path.
package cpu_types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  regbits_t;

    typedef enum logic [5:0] {
        RTYPE = 6'h00,
        BEQ   = 6'h04,
        LW    = 6'h23,
        SW    = 6'h2B,
        HALT  = 6'h3F
    } opcode_t;

endpackage

// File: rtl/decode_issue_queue_pkg.sv
// decode_issue_queue_pkg: helpers shared by the issue queue and its sub-block.
// No ports.
package decode_issue_queue_pkg;

    import cpu_types_pkg::*;

    // True when the 6-bit opcode field names the HALT instruction.
    function automatic logic is_halt(input logic [5:0] op);
        return opcode_t'(op) == HALT;
    endfunction

endpackage

// File: rtl/decode_issue_queue_if.sv
// decode_issue_queue_if: fetch/decode side handshake of the issue queue.
//   master : fetch + decode + EX-stage load info (drives flush, enq_*, deq_ready, ex_load_*)
//   slave  : the queue (drives enq_ready, deq_*, count, halt_seen)
interface decode_issue_queue_if #(
    parameter int DEPTH = 4,
    parameter int IW    = 32,
    parameter int RW    = 5
);
    logic                     flush;
    logic                     enq_valid;
    logic [IW-1:0]            enq_instr;
    logic [IW-1:0]            enq_npc;
    logic                     enq_ready;
    logic                     deq_ready;
    logic                     deq_valid;
    logic [IW-1:0]            deq_instr;
    logic [IW-1:0]            deq_npc;
    logic                     deq_bubble;
    logic                     ex_load_valid;
    logic [RW-1:0]            ex_load_dst;
    logic [$clog2(DEPTH):0]   count;
    logic                     halt_seen;

    modport master (
        output flush, enq_valid, enq_instr, enq_npc, deq_ready, ex_load_valid, ex_load_dst,
        input  enq_ready, deq_valid, deq_instr, deq_npc, deq_bubble, count, halt_seen
    );

    modport slave (
        input  flush, enq_valid, enq_instr, enq_npc, deq_ready, ex_load_valid, ex_load_dst,
        output enq_ready, deq_valid, deq_instr, deq_npc, deq_bubble, count, halt_seen
    );

endinterface

// File: rtl/decode_issue_queue_hazard_chk.sv
// iq_hazard_chk: combinational load-use comparator for the queue head.
//   head_valid_i      : queue holds at least one entry
//   head_rs_i/rt_i    : source register fields of the head instruction
//   load_valid_i      : EX stage holds a load
//   load_dst_i        : destination register of that load
//   hazard_o          : head must wait one cycle (register 0 never conflicts)
module iq_hazard_chk #(
    parameter int RW = 5
) (
    input  logic          head_valid_i,
    input  logic [RW-1:0] head_rs_i,
    input  logic [RW-1:0] head_rt_i,
    input  logic          load_valid_i,
    input  logic [RW-1:0] load_dst_i,
    output logic          hazard_o
);

    assign hazard_o = head_valid_i && load_valid_i && (load_dst_i != '0) &&
                      ((load_dst_i == head_rs_i) || (load_dst_i == head_rt_i));

endmodule

// File: rtl/decode_issue_queue.sv
// decode_issue_queue: circular instruction queue between fetch and decode with
// load-use interlock on the head and a sticky HALT-seen flag.
//   CLK, RST : clock and synchronous active-high reset
//   bus      : slave side of decode_issue_queue_if (enqueue, dequeue, EX load, status)
module decode_issue_queue
    import cpu_types_pkg::*;
    import control_unit_pkg::*;
    import decode_issue_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int IW    = 32,
    parameter int RW    = 5
) (
    input logic                  CLK,
    input logic                  RST,
    decode_issue_queue_if.slave  bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [IW-1:0] instr_mem [DEPTH];
    logic [IW-1:0] npc_mem   [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;
    logic          halt_seen_q, halt_seen_d;

    logic          not_empty;
    logic          hazard;
    logic          enq_ready;
    logic          deq_valid;
    logic          enq_fire;
    logic          deq_fire;
    logic [IW-1:0] head_instr;
    logic [IW-1:0] head_npc;

    assign head_instr = instr_mem[rd_ptr_q];
    assign head_npc   = npc_mem[rd_ptr_q];
    assign not_empty  = (count_q != '0);

    iq_hazard_chk #(.RW(RW)) u_hazard (
        .head_valid_i (not_empty),
        .head_rs_i    (head_instr[RS_LSB +: RW]),
        .head_rt_i    (head_instr[RT_LSB +: RW]),
        .load_valid_i (bus.ex_load_valid),
        .load_dst_i   (bus.ex_load_dst),
        .hazard_o     (hazard)
    );

    // A full queue refuses enqueue even when the head leaves this same cycle.
    assign enq_ready = (count_q != CW'(DEPTH)) && !halt_seen_q;
    assign deq_valid = not_empty && !hazard;
    assign enq_fire  = bus.enq_valid && enq_ready;
    assign deq_fire  = deq_valid && bus.deq_ready;

    assign bus.enq_ready  = enq_ready;
    assign bus.deq_valid  = deq_valid;
    assign bus.deq_bubble = hazard;
    assign bus.deq_instr  = not_empty ? head_instr : '0;
    assign bus.deq_npc    = not_empty ? head_npc   : '0;
    assign bus.count      = count_q;
    assign bus.halt_seen  = halt_seen_q;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        halt_seen_d = halt_seen_q;
        if (bus.flush) begin
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            halt_seen_d = 1'b0;
        end else begin
            if (enq_fire) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (deq_fire) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
                if (is_halt(head_instr[OP_LSB +: 6])) begin
                    halt_seen_d = 1'b1;
                end
            end
            case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            halt_seen_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            halt_seen_q <= halt_seen_d;
        end
    end

    // Storage is not reset; entries are only visible while count is non-zero.
    always_ff @(posedge CLK) begin
        if (enq_fire && !bus.flush && !RST) begin
            instr_mem[wr_ptr_q] <= bus.enq_instr;
            npc_mem[wr_ptr_q]   <= bus.enq_npc;
        end
    end

endmodule

// File: doc/decode_issue_queue.md
DECODE_ISSUE_QUEUE -- requirements
Module: decode_issue_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries (power of two, >= 2).
REQ-002 SHALL have parameter IW, default 32, meaning instruction/PC width in bits.
REQ-003 SHALL have parameter RW, default 5, meaning register-index width.
REQ-004 SHALL have one clock and a synchronous, active-high reset, with ports CLK and RST.
REQ-005 CLK  input  1  clock, all state updates on rising edge.
REQ-006 RST  input  1  synchronous active-high reset.
REQ-007 flush  input  1  discard all queued instructions (branch/jump redirect).
REQ-008 enq_valid  input  1  fetch presents an instruction (driven by ihit).
REQ-009 enq_instr  input  IW  fetched instruction.
REQ-010 enq_npc  input  IW  PC+4 of fetched instruction.
REQ-011 enq_ready  output  1  queue accepts an enqueue this cycle.
REQ-012 deq_ready  input  1  decode/execute consumes the head this cycle.
REQ-013 deq_valid  output  1  head is valid and hazard-free.
REQ-014 deq_instr  output  IW  head instruction.
REQ-015 deq_npc  output  IW  head PC+4.
REQ-016 deq_bubble  output  1  head is held by a load-use interlock; downstream inserts a NOP.
REQ-017 ex_load_valid  input  1  instruction in EX is a load (dREN).
REQ-018 ex_load_dst  input  RW  destination register of that load.
REQ-019 count  output  $clog2(DEPTH)+1  occupied entries.
REQ-020 halt_seen  output  1  HALT has been dequeued; fetch side frozen.

Function
REQ-021 SHALL store entries in a circular buffer with wr_ptr/rd_ptr of $clog2(DEPTH) bits that wrap modulo DEPTH.
REQ-022 SHALL drive enq_ready = (count != DEPTH) && !halt_seen; a full queue refuses enqueue even if a dequeue occurs in the same cycle.
REQ-023 SHALL enqueue when enq_valid && enq_ready: write the entry at wr_ptr, advance wr_ptr, and increment count.
REQ-024 SHALL drive deq_instr/deq_npc combinationally from the head entry, and drive both as 0 when count == 0.
REQ-025 SHALL assert hazard when count != 0 && ex_load_valid && ex_load_dst != 0 && (ex_load_dst == head rs[25:21] || ex_load_dst == head rt[20:16]).
REQ-026 SHALL drive deq_valid = (count != 0) && !hazard, and deq_bubble = hazard.
REQ-027 SHALL dequeue when deq_valid && deq_ready: advance rd_ptr and decrement count; if enqueue also occurs in that cycle, count is unchanged.
REQ-028 SHALL set halt_seen on the cycle after a dequeue whose opcode [31:26] equals HALT; it stays set until flush or RST.
REQ-029 SHALL, on flush, zero count and both pointers and clear halt_seen next cycle; flush overrides any enqueue or dequeue in the same cycle.
REQ-030 SHALL treat deq_ready while deq_valid = 0 as a no-op, and enq_valid while enq_ready = 0 as a no-op (no state change).
REQ-031 SHALL give a one-cycle latency from enqueue to availability at the head (an empty queue is not bypassed).

Reset
REQ-032 SHALL, when RST = 1 at a clock edge, set count = 0, wr_ptr = rd_ptr = 0, and halt_seen = 0; the outputs then read enq_ready = 1, deq_valid = 0, deq_bubble = 0, deq_instr = 0, deq_npc = 0.
REQ-033 SHALL give RST priority over flush, enqueue and dequeue, including mid-operation with a full queue.
REQ-034 SHALL leave storage array contents unreset; they are unobservable while count = 0.

Structure
REQ-035 SHALL take the HALT opcode, opcode_t, word_t and regbits_t from cpu_types_pkg; the field-offset constants (RS_LSB = 21, RT_LSB = 16, OP_LSB = 26) belong in control_unit_pkg.
REQ-036 SHALL contain one natural sub-module, iq_hazard_chk, a combinational load-use comparator; the storage is inline.

Verification
REQ-037 Reset, then enqueue 0x8C220004 (npc 0x4), 1 cycle -> deq_valid = 1, deq_instr = 0x8C220004, deq_npc = 0x4, count = 1.
REQ-038 Enqueue 4 instructions with deq_ready = 0 -> count = 4, enq_ready = 0; a 5th enqueue is ignored; dequeue all 4 -> FIFO order preserved, pointers wrap, count = 0.
REQ-039 Head 0x00431020 (rs = 2), ex_load_valid = 1, ex_load_dst = 2 -> deq_valid = 0, deq_bubble = 1; drop ex_load_valid -> deq_valid = 1 next cycle; ex_load_dst = 0 never stalls.
REQ-040 count = 3 with simultaneous enqueue, dequeue and flush -> next cycle count = 0, deq_valid = 0, enq_ready = 1.
REQ-041 Dequeue 0xFFFFFFFF (HALT) -> halt_seen = 1 next cycle, enq_ready = 0; flush -> halt_seen = 0, enq_ready = 1.
REQ-042 Full queue, RST = 1 -> count = 0, deq_valid = 0, halt_seen = 0 next cycle.
